ext_int_ctrl_param: RTL and testbench

Parametrised external interrupt controller, the next generation of the IO subsystem's fixed 8-line EIC. It collects NUM_IRQ peripheral request lines and supports per-line mask and per-line edge/level mode. It arbitrates by fixed priority and presents one request plus ID to the processor using a req/ack handshake. Software reaches it through a block-selected register window on the system bus.

---
 rtl/eic_pkg.sv | 18 +
 rtl/irq_sync_edge.sv | 31 +++
 rtl/ext_int_ctrl_param.sv | 123 ++++++++++++
 tb/tb_ext_int_ctrl_param.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eic_pkg.sv
// Shared definitions for the external interrupt controller: register
// window offsets and handshake FSM states.
package eic_pkg;

  localparam logic [3:0] EIC_CTRL    = 4'd0;
  localparam logic [3:0] EIC_MASK    = 4'd1;
  localparam logic [3:0] EIC_MODE    = 4'd2;
  localparam logic [3:0] EIC_PENDING = 4'd3;
  localparam logic [3:0] EIC_STATUS  = 4'd4;
  localparam logic [3:0] EIC_RAW     = 4'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } eic_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-stage synchronizer for asynchronous request lines; provides the
// synchronized level and a one-cycle rising-edge pulse per line.
module irq_sync_edge #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= din;
      for (int unsigned i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;

endmodule

// File: rtl/ext_int_ctrl_param.sv
// Parametrised external interrupt controller: masked, edge/level request
// lines, fixed highest-index priority, req/ack handshake to the processor.
module ext_int_ctrl_param
  import eic_pkg::*;
#(
  parameter int  NUM_IRQ     = 8,
  parameter int  SYNC_STAGES = 2,
  localparam int ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               Sys_Clock,
  input  logic               Sys_Reset,
  input  logic               Sys_BlockSelect,
  input  logic [3:0]         Sys_RegAddress,
  input  logic               Sys_WrEn,
  input  logic               Sys_RdEn,
  input  logic [31:0]        Sys_WrData,
  output logic [31:0]        Sys_RdData,
  input  logic [NUM_IRQ-1:0] IntReq,
  output logic               EIC_IntReq,
  output logic [ID_W-1:0]    EIC_IntId,
  input  logic               EIC_IntAck
);

  logic               ctrl_en;
  logic [NUM_IRQ-1:0] mask, mode, pending, level, rise;
  logic [NUM_IRQ-1:0] w1c, ack_clr, pending_nxt, eligible;
  logic [ID_W-1:0]    win_id;
  logic               wr_sel, rd_sel, ack_take;
  logic [31:0]        rd_mux;
  eic_state_e         state;
  logic               unused_wr;

  assign unused_wr = ^Sys_WrData;

  irq_sync_edge #(.WIDTH(NUM_IRQ), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (Sys_Clock),
    .rst_n (Sys_Reset),
    .din   (IntReq),
    .level (level),
    .rise  (rise)
  );

  assign wr_sel   = Sys_BlockSelect & Sys_WrEn;
  assign rd_sel   = Sys_BlockSelect & Sys_RdEn;
  assign ack_take = (state == REQ) & EIC_IntAck;
  assign w1c      = (wr_sel && Sys_RegAddress == EIC_PENDING) ? Sys_WrData[NUM_IRQ-1:0] : '0;
  assign eligible = ctrl_en ? (pending & mask) : '0;

  // Edge-mode bits: a new edge wins over W1C/ack; level-mode bits track the input.
  assign pending_nxt = (mode & ((pending & ~(w1c | ack_clr)) | rise)) | (~mode & level);

  always_comb begin
    ack_clr = '0;
    win_id  = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      ack_clr[i] = ack_take && (EIC_IntId == ID_W'(i));
      if (eligible[i]) win_id = ID_W'(i);
    end
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      ctrl_en <= 1'b0;
      mask    <= '0;
      mode    <= '1;
      pending <= '0;
    end else begin
      pending <= pending_nxt;
      if (wr_sel) begin
        case (Sys_RegAddress)
          EIC_CTRL: ctrl_en <= Sys_WrData[0];
          EIC_MASK: mask    <= Sys_WrData[NUM_IRQ-1:0];
          EIC_MODE: mode    <= Sys_WrData[NUM_IRQ-1:0];
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      state      <= IDLE;
      EIC_IntReq <= 1'b0;
      EIC_IntId  <= '0;
    end else begin
      case (state)
        IDLE: if (|eligible) begin
          EIC_IntId  <= win_id;
          EIC_IntReq <= 1'b1;
          state      <= REQ;
        end
        REQ: if (EIC_IntAck) begin
          EIC_IntReq <= 1'b0;
          state      <= GAP;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (Sys_RegAddress)
      EIC_CTRL:    rd_mux[0]           = ctrl_en;
      EIC_MASK:    rd_mux[NUM_IRQ-1:0] = mask;
      EIC_MODE:    rd_mux[NUM_IRQ-1:0] = mode;
      EIC_PENDING: rd_mux[NUM_IRQ-1:0] = pending;
      EIC_STATUS: begin
        rd_mux[31]     = EIC_IntReq;
        rd_mux[ID_W-1:0] = EIC_IntId;
      end
      EIC_RAW:     rd_mux[NUM_IRQ-1:0] = level;
      default:     ;
    endcase
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) Sys_RdData <= '0;
    else            Sys_RdData <= rd_sel ? rd_mux : '0;
  end

endmodule

// File: tb/tb_ext_int_ctrl_param.sv
// Directed bench for ext_int_ctrl_param (NUM_IRQ=8, SYNC_STAGES=2):
// register table plus hand-written handshake sequences.
module tb_ext_int_ctrl_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bsel, wren, rden, ack;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata;
  logic [7:0]  irq;
  logic        int_req;
  logic [2:0]  int_id;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          sel;
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t reset_tbl[$];
  vec_t rw_tbl[$];

  always #5 clk = ~clk;

  ext_int_ctrl_param #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
    .Sys_Clock       (clk),
    .Sys_Reset       (rst_n),
    .Sys_BlockSelect (bsel),
    .Sys_RegAddress  (addr),
    .Sys_WrEn        (wren),
    .Sys_RdEn        (rden),
    .Sys_WrData      (wdata),
    .Sys_RdData      (rdata),
    .IntReq          (irq),
    .EIC_IntReq      (int_req),
    .EIC_IntId       (int_id),
    .EIC_IntAck      (ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_vec(input vec_t v);
    bsel = v.sel;
    addr = v.addr;
    if (v.wr) begin
      wren = 1'b1; wdata = v.data;
      tick();
      wren = 1'b0; bsel = 1'b0;
    end else begin
      rden = 1'b1;
      tick();
      rden = 1'b0; bsel = 1'b0;
      check($sformatf("reg_rd[%0d]", v.addr), rdata, v.exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    do_vec('{1'b1, 1'b1, a, d, 32'h0});
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    do_vec('{1'b1, 1'b0, a, 32'h0, e});
  endtask

  task automatic pulse(input logic [7:0] lines);
    irq = irq | lines;
    tick();
    irq = irq & ~lines;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // Cycles until EIC_IntReq rises, -1 if it never does within the budget.
  task automatic wait_req(input string name, input int exp_n, input logic [2:0] exp_id);
    int n;
    n = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (int_req) begin
        n = i;
        break;
      end
    end
    check({name, "_latency"}, 32'(n), 32'(exp_n));
    check({name, "_id"}, 32'(int_id), 32'(exp_id));
  endtask

  task automatic quiet(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      check(name, 32'(int_req), 32'h0);
    end
  endtask

  initial begin
    reset_tbl.push_back('{1'b1, 1'b0, 4'd0,  32'h0, 32'h0});
    reset_tbl.push_back('{1'b1, 1'b0, 4'd1,  32'h0, 32'h0});
    reset_tbl.push_back('{1'b1, 1'b0, 4'd2,  32'h0, 32'hFF});
    reset_tbl.push_back('{1'b1, 1'b0, 4'd3,  32'h0, 32'h0});
    reset_tbl.push_back('{1'b1, 1'b0, 4'd4,  32'h0, 32'h0});
    reset_tbl.push_back('{1'b1, 1'b0, 4'd5,  32'h0, 32'h0});
    reset_tbl.push_back('{1'b1, 1'b0, 4'd6,  32'h0, 32'h0});
    reset_tbl.push_back('{1'b1, 1'b0, 4'd15, 32'h0, 32'h0});
    reset_tbl.push_back('{1'b0, 1'b0, 4'd2,  32'h0, 32'h0});

    rw_tbl.push_back('{1'b1, 1'b1, 4'd1, 32'h000000A5, 32'h0});
    rw_tbl.push_back('{1'b1, 1'b0, 4'd1, 32'h0,        32'hA5});
    rw_tbl.push_back('{1'b1, 1'b1, 4'd2, 32'hFFFF0F3C, 32'h0});
    rw_tbl.push_back('{1'b1, 1'b0, 4'd2, 32'h0,        32'h3C});
    rw_tbl.push_back('{1'b0, 1'b1, 4'd2, 32'h000000FF, 32'h0});
    rw_tbl.push_back('{1'b1, 1'b0, 4'd2, 32'h0,        32'h3C});
    rw_tbl.push_back('{1'b1, 1'b1, 4'd0, 32'hFFFFFFFF, 32'h0});
    rw_tbl.push_back('{1'b1, 1'b0, 4'd0, 32'h0,        32'h1});
    rw_tbl.push_back('{1'b1, 1'b1, 4'd9, 32'h00001234, 32'h0});
    rw_tbl.push_back('{1'b1, 1'b0, 4'd9, 32'h0,        32'h0});
    rw_tbl.push_back('{1'b1, 1'b1, 4'd4, 32'hFFFFFFFF, 32'h0});
    rw_tbl.push_back('{1'b1, 1'b0, 4'd4, 32'h0,        32'h0});
    rw_tbl.push_back('{1'b1, 1'b1, 4'd5, 32'hFFFFFFFF, 32'h0});
    rw_tbl.push_back('{1'b1, 1'b0, 4'd5, 32'h0,        32'h0});
    rw_tbl.push_back('{1'b1, 1'b1, 4'd0, 32'h0,        32'h0});
    rw_tbl.push_back('{1'b1, 1'b1, 4'd1, 32'h0,        32'h0});
    rw_tbl.push_back('{1'b1, 1'b1, 4'd2, 32'h000000FF, 32'h0});
    rw_tbl.push_back('{1'b1, 1'b0, 4'd2, 32'h0,        32'hFF});

    rst_n = 1'b0; bsel = 1'b0; wren = 1'b0; rden = 1'b0; ack = 1'b0;
    addr = '0; wdata = '0; irq = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("reset_req", 32'(int_req), 32'h0);
    check("reset_id", 32'(int_id), 32'h0);
    foreach (reset_tbl[i]) do_vec(reset_tbl[i]);
    foreach (rw_tbl[i]) do_vec(rw_tbl[i]);

    // RAW shows the synchronized level two cycles after the pin.
    irq = 8'h02;
    repeat (3) tick();
    rd(4'd5, 32'h02);
    irq = 8'h00;
    repeat (3) tick();
    wr(4'd3, 32'hFF);
    rd(4'd3, 32'h00);

    // Edge, single line: 4 cycles pin to request, held until ack.
    wr(4'd0, 32'h1);
    wr(4'd1, 32'h80);
    pulse(8'h80);
    wait_req("edge7", 3, 3'd7);
    repeat (3) tick();
    check("edge7_hold", 32'(int_req), 32'h1);
    rd(4'd4, 32'h80000007);
    do_ack();
    check("edge7_gap", 32'(int_req), 32'h0);
    rd(4'd3, 32'h00);
    quiet("edge7_no_rereq", 4);

    // Priority: lines 2 and 5 together, 5 first.
    wr(4'd1, 32'hFF);
    pulse(8'h24);
    wait_req("prio_first", 3, 3'd5);
    do_ack();
    check("prio_gap", 32'(int_req), 32'h0);
    wait_req("prio_second", 2, 3'd2);
    do_ack();

    // Masking and global enable.
    wr(4'd1, 32'h00);
    pulse(8'h08);
    quiet("masked_no_req", 6);
    rd(4'd3, 32'h08);
    wr(4'd1, 32'h08);
    wait_req("unmask3", 1, 3'd3);
    wr(4'd0, 32'h0);
    repeat (3) tick();
    check("disable_holds_req", 32'(int_req), 32'h1);
    check("disable_holds_id", 32'(int_id), 32'h3);
    do_ack();
    wr(4'd1, 32'h48);
    pulse(8'h40);
    quiet("disabled_no_req", 6);
    wr(4'd0, 32'h1);
    wait_req("enable6", 1, 3'd6);
    do_ack();

    // Level mode on line 0.
    wr(4'd1, 32'h01);
    wr(4'd2, 32'hFE);
    irq[0] = 1'b1;
    wait_req("level0", 4, 3'd0);
    do_ack();
    check("level0_gap", 32'(int_req), 32'h0);
    wait_req("level0_again", 2, 3'd0);
    wr(4'd3, 32'h01);
    rd(4'd3, 32'h01);
    irq[0] = 1'b0;
    repeat (4) tick();
    check("level0_held", 32'(int_req), 32'h1);
    rd(4'd3, 32'h00);
    do_ack();
    quiet("level0_dropped", 6);
    wr(4'd2, 32'hFF);
    rd(4'd3, 32'h00);

    // New edge on line 4 coincident with its ack: pending survives.
    wr(4'd1, 32'h10);
    pulse(8'h10);
    wait_req("sim_ack", 3, 3'd4);
    irq[4] = 1'b1;
    tick();
    irq[4] = 1'b0;
    tick();
    do_ack();
    check("sim_ack_gap", 32'(int_req), 32'h0);
    rd(4'd3, 32'h10);
    wait_req("sim_ack_re", 1, 3'd4);
    do_ack();
    tick();
    rd(4'd3, 32'h00);

    // W1C coincident with an edge on line 4: set wins.
    wr(4'd1, 32'h00);
    irq[4] = 1'b1;
    tick();
    irq[4] = 1'b0;
    tick();
    wr(4'd3, 32'h10);
    rd(4'd3, 32'h10);
    wr(4'd3, 32'h10);
    rd(4'd3, 32'h00);

    // Reset asserted while a request is outstanding.
    wr(4'd1, 32'h10);
    pulse(8'h10);
    wait_req("rst_pre", 3, 3'd4);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_req", 32'(int_req), 32'h0);
    check("rst_async_id", 32'(int_id), 32'h0);
    check("rst_async_rd", rdata, 32'h0);
    #10 rst_n = 1'b1;
    quiet("rst_no_rereq", 8);
    foreach (reset_tbl[i]) do_vec(reset_tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
